half_subtractor_design: RTL and testbench

Registered multi-lane 1-bit half subtractor. Each lane computes a - b for one bit pair and produces a difference bit and a borrow-out bit. The block sits as a leaf datapath element in the arithmetic library. With the default WIDTH=1 it is a single clocked half subtractor.

---
 rtl/half_subtractor_design.sv | 94 +++++++++
 tb/tb_half_subtractor_design.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/half_subtractor_design.sv
// ---------------------------------------------------------------------------
// half_subtractor_design
//
// Registered multi-lane 1-bit half subtractor. Each lane computes a[i] - b[i]
// and registers a difference bit and a borrow-out bit. The lanes are
// independent, so no borrow passes from one lane to the next.
//
// Valid semantics: this block always accepts. A sample is taken when
// in_valid=1 at a rising clk edge. Its results appear on diff/borrow/
// borrow_any right after that edge, and out_valid is high for that one
// cycle. Back-to-back samples give one result per cycle. When in_valid=0 the
// results hold and out_valid drops. There is no ready, so nothing ever stalls.
//
// Optional feature: define HALF_SUB_STATS_EN to add a saturating counter of
// borrowing samples (stat_clr input, borrow_events output).
//
// Parameters:
//   WIDTH  number of half-subtractor lanes (1..64)
//   CNT_W  width of the borrow-event counter (used only with the feature)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset, wins over in_valid
//   in_valid       take a/b on this edge
//   a, b           minuend / subtrahend, one bit per lane
//   stat_clr       (feature) synchronous clear of borrow_events
//   borrow_events  (feature) saturating count of samples with any borrow
//   diff           registered a ^ b per lane
//   borrow         registered ~a & b per lane
//   out_valid      high for one cycle after each accepted sample
//   borrow_any     registered OR of the borrow bits of the last sample
// ---------------------------------------------------------------------------
module half_subtractor_design #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef HALF_SUB_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] borrow_events,
`endif
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             out_valid,
  output logic             borrow_any
);

  // Catch an unsupported configuration at elaboration time.
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
    $error("half_subtractor_design: WIDTH must be 1..64 and CNT_W >= 1");
  end

  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] borrow_next;
  logic             borrow_any_next;

  always_comb begin
    diff_next       = a ^ b;
    borrow_next     = ~a & b;
    borrow_any_next = |borrow_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff       <= '0;
      borrow     <= '0;
      borrow_any <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff       <= diff_next;
        borrow     <= borrow_next;
        borrow_any <= borrow_any_next;
      end
    end
  end

`ifdef HALF_SUB_STATS_EN
  // The clear wins over a simultaneous increment. The count stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      borrow_events <= '0;
    end else if (in_valid && borrow_any_next && (borrow_events != {CNT_W{1'b1}})) begin
      borrow_events <= borrow_events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_half_subtractor_design.sv
// ---------------------------------------------------------------------------
// tb_half_subtractor_design
//
// Drives half_subtractor_design with WIDTH=4 (and CNT_W=2 for the optional
// counter, when HALF_SUB_STATS_EN is defined). Each step drives inputs on
// the falling edge and updates an arithmetic reference model at the rising
// edge. The model's expected outputs go into exp_q, and the bench compares
// them with the DUT 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_half_subtractor_design;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int EW = 2 * W + 2;

  // clock
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic         rst      = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic [W-1:0] diff;
  logic [W-1:0] borrow;
  logic         out_valid;
  logic         borrow_any;
`ifdef HALF_SUB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [CW-1:0] borrow_events;
  int unsigned   m_cnt;
`endif

  half_subtractor_design #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
`ifdef HALF_SUB_STATS_EN
    .stat_clr     (stat_clr),
    .borrow_events(borrow_events),
`endif
    .diff       (diff),
    .borrow     (borrow),
    .out_valid  (out_valid),
    .borrow_any (borrow_any)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0] m_diff   = '0;
  logic [W-1:0] m_borrow = '0;
  logic         m_valid  = 1'b0;
  logic         m_any    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // For each lane, the difference is (a - b) mod 2. A negative result means
  // a borrow.
  task automatic model_edge(input logic r, input logic v,
                            input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic clr);
    bit lane_borrow = 1'b0;
    if (r) begin
      m_diff   = '0;
      m_borrow = '0;
      m_valid  = 1'b0;
      m_any    = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        for (int i = 0; i < W; i++) begin
          int d;
          d = int'(aa[i]) - int'(bb[i]);
          m_diff[i]   = ((d % 2) != 0);
          m_borrow[i] = (d < 0);
          if (d < 0) lane_borrow = 1'b1;
        end
        m_any = lane_borrow;
      end
    end
`ifdef HALF_SUB_STATS_EN
    if (r || clr) m_cnt = 0;
    else if (v && lane_borrow && m_cnt < (1 << CW) - 1) m_cnt++;
`else
    if (clr) lane_borrow = 1'b0;
`endif
    exp_q.push_back({m_valid, m_any, m_borrow, m_diff});
  endtask

  // driver: one clock step with checking
  task automatic step(input string ph, input logic r, input logic v,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic clr);
    logic [EW-1:0] e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = aa;
    b        = bb;
`ifdef HALF_SUB_STATS_EN
    stat_clr = clr;
`endif
    @(posedge clk);
    model_edge(r, v, aa, bb, clr);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_queue: got empty expected entry", ph);
    end else begin
      e = exp_q.pop_front();
      check({ph, "_diff"},       64'(diff),       64'(e[W-1:0]));
      check({ph, "_borrow"},     64'(borrow),     64'(e[2*W-1:W]));
      check({ph, "_borrow_any"}, 64'(borrow_any), 64'(e[2*W]));
      check({ph, "_out_valid"},  64'(out_valid),  64'(e[2*W+1]));
    end
`ifdef HALF_SUB_STATS_EN
    check({ph, "_events"}, 64'(borrow_events), 64'(m_cnt));
`endif
  endtask

  initial begin
    logic [W-1:0] ta;
    logic [W-1:0] tb;

    // Reset held for 2 cycles while a sample is offered: it must be dropped.
    step("rst", 1'b1, 1'b1, W'(1), W'(0), 1'b0);
    step("rst", 1'b1, 1'b1, W'(1), W'(0), 1'b0);
    check("rst_diff_zero", 64'(diff), 64'd0);
    check("rst_out_valid_zero", 64'(out_valid), 64'd0);

    // Truth table: lane i gets pattern (p+i)%4, so every step covers all
    // four (a,b) pairs across the lanes.
    for (int p = 0; p < 4; p++) begin
      ta = '0;
      tb = '0;
      for (int i = 0; i < W; i++) begin
        int q;
        q = (p + i) % 4;
        ta[i] = q[1];
        tb[i] = q[0];
      end
      step("tt", 1'b0, 1'b1, ta, tb, 1'b0);
    end

    // Hold: accept 0-1, then idle with inputs toggling.
    step("hold_acc", 1'b0, 1'b1, '0, '1, 1'b0);
    for (int k = 0; k < 3; k++)
      step("hold", 1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0);
    check("hold_diff_const", 64'(diff), 64'hF);
    check("hold_borrow_const", 64'(borrow), 64'hF);

    // Directed four-lane vectors.
    step("w4a", 1'b0, 1'b1, 4'b1010, 4'b0110, 1'b0);
    check("w4a_diff_const", 64'(diff), 64'b1100);
    check("w4a_borrow_const", 64'(borrow), 64'b0100);
    check("w4a_any_const", 64'(borrow_any), 64'd1);
    step("w4b", 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0);
    check("w4b_diff_const", 64'(diff), 64'b1111);
    check("w4b_any_const", 64'(borrow_any), 64'd0);

    // Reset in the middle of a stream.
    for (int k = 0; k < 3; k++)
      step("stream", 1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0);
    step("mid_rst", 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0);
    check("mid_rst_borrow_zero", 64'(borrow), 64'd0);
    step("post_rst", 1'b0, 1'b1, 4'b0011, 4'b0101, 1'b0);
    check("post_rst_diff_const", 64'(diff), 64'b0110);
    step("post_idle", 1'b0, 1'b0, W'($urandom), W'($urandom), 1'b0);

`ifdef HALF_SUB_STATS_EN
    // The counter saturates at 3 with CNT_W=2. A clear beats a borrowing
    // sample on the same edge.
    step("st_clr", 1'b0, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 5; k++)
      step("st_inc", 1'b0, 1'b1, '0, W'($urandom_range(1, (1 << W) - 1)), 1'b0);
    check("st_saturated", 64'(borrow_events), 64'd3);
    step("st_clr_inc", 1'b0, 1'b1, '0, '1, 1'b1);
    check("st_cleared", 64'(borrow_events), 64'd0);
`endif

    // Random mix of valid, idle, reset and clear.
    for (int k = 0; k < 300; k++)
      step("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           W'($urandom), W'($urandom), ($urandom_range(0, 9) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
